// File: rtl/data_mem_responder.sv
// data_mem_responder
// Single-port word-organised data memory behind a valid/ready request and
// response handshake. Each request takes 1+WAIT_CYCLES cycles to respond,
// supports RV32I byte/halfword/word loads and stores, and reports misaligned,
// out-of-range or illegal accesses as errors without side effects.
// Storage is never cleared by reset; it relies on power-up zero contents.

module data_mem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_error
);

   // Byte-address width covering the whole array, and word-index width.
   localparam int          ADDR_W     = $clog2(4 * DEPTH_WORDS);
   localparam int          IDX_W      = ADDR_W - 2;
   localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

   // Counter reload value; only meaningful when WAIT_CYCLES > 0.
   localparam int          CNT_LOAD_I = (WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0;
   localparam logic [3:0]  CNT_LOAD   = 4'(CNT_LOAD_I);

   // RV32I load/store width codes.
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      RESP = 2'b10
   } state_t;

   // Classify an access: illegal width code, unsigned store, misalignment,
   // or a byte address beyond the array all reject the request.
   function automatic logic access_error(input logic        wr,
                                         input logic [31:0] addr,
                                         input logic [2:0]  f3);
      logic bad;
      case (f3)
         F3_B:    bad = 1'b0;
         F3_BU:   bad = wr;
         F3_H:    bad = addr[0];
         F3_HU:   bad = wr | addr[0];
         F3_W:    bad = (addr[1:0] != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad | (addr >= ADDR_LIMIT);
   endfunction

   // Byte-lane enables for a store of the given width at the given offset.
   function automatic logic [3:0] lane_mask(input logic [2:0] f3,
                                            input logic [1:0] off);
      logic [3:0] m;
      case (f3[1:0])
         2'b00:   m = 4'b0001 << off;
         2'b01:   m = 4'b0011 << off;
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

   // Move LSB-aligned store data up to its byte lanes.
   function automatic logic [31:0] store_align(input logic [31:0] wdata,
                                               input logic [1:0]  off);
      return wdata << {off, 3'b000};
   endfunction

   // Bring the addressed byte/halfword down to bit 0 and extend it.
   function automatic logic [31:0] load_extend(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [2:0]  f3);
      logic [31:0] sh;
      logic [31:0] res;
      sh = word >> {off, 3'b000};
      case (f3)
         F3_B:    res = {{24{sh[7]}}, sh[7:0]};
         F3_BU:   res = {24'h000000, sh[7:0]};
         F3_H:    res = {{16{sh[15]}}, sh[15:0]};
         F3_HU:   res = {16'h0000, sh[15:0]};
         F3_W:    res = word;
         default: res = 32'h0000_0000;
      endcase
      return res;
   endfunction

   // Storage array (no reset).
   logic [31:0] mem_r [DEPTH_WORDS];

   // FSM and counter.
   state_t      state_r;
   state_t      state_s;
   logic [3:0]  cnt_r;
   logic [3:0]  cnt_s;

   // Request captured at the accepting edge.
   logic        lat_write_r;
   logic [31:0] lat_addr_r;
   logic [2:0]  lat_funct3_r;
   logic [31:0] lat_wdata_r;

   // Registered outputs.
   logic        ready_r;
   logic        rsp_valid_r;
   logic [31:0] rsp_rdata_r;
   logic        rsp_error_r;

   // Access-path signals.
   logic             accept_s;
   logic             enter_resp_s;
   logic             acc_write_s;
   logic [31:0]      acc_addr_s;
   logic [2:0]       acc_funct3_s;
   logic [31:0]      acc_wdata_s;
   logic             acc_error_s;
   logic [IDX_W-1:0] word_idx_s;
   logic [31:0]      rd_word_s;
   logic [3:0]       wmask_s;
   logic [31:0]      wdata_al_s;
   logic [31:0]      load_data_s;
   logic             mem_we_s;

   // ready_r is only ever high while in IDLE, so it doubles as the accept qualifier.
   assign accept_s = req_valid & ready_r;

   // Select the access source: live inputs when a zero-wait request is being
   // accepted this edge, otherwise the captured request.
   always_comb begin
      acc_write_s  = lat_write_r;
      acc_addr_s   = lat_addr_r;
      acc_funct3_s = lat_funct3_r;
      acc_wdata_s  = lat_wdata_r;
      if (accept_s) begin
         acc_write_s  = req_write;
         acc_addr_s   = req_addr;
         acc_funct3_s = req_funct3;
         acc_wdata_s  = req_wdata;
      end else begin
         acc_write_s  = lat_write_r;
         acc_addr_s   = lat_addr_r;
         acc_funct3_s = lat_funct3_r;
         acc_wdata_s  = lat_wdata_r;
      end
   end

   // Decode the selected access into error flag, array index, lanes and data.
   always_comb begin
      acc_error_s = access_error(acc_write_s, acc_addr_s, acc_funct3_s);
      word_idx_s  = acc_addr_s[ADDR_W-1:2];
      rd_word_s   = mem_r[word_idx_s];
      wmask_s     = lane_mask(acc_funct3_s, acc_addr_s[1:0]);
      wdata_al_s  = store_align(acc_wdata_s, acc_addr_s[1:0]);
      load_data_s = load_extend(rd_word_s, acc_addr_s[1:0], acc_funct3_s);
   end

   // Next-state and counter logic for the IDLE/WAIT/RESP sequencer.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               if (WAIT_CYCLES == 0) begin
                  state_s = RESP;
               end else begin
                  state_s = WAIT;
                  cnt_s   = CNT_LOAD;
               end
            end else begin
               state_s = IDLE;
            end
         end
         WAIT: begin
            if (cnt_r == 4'd0) begin
               state_s = RESP;
            end else begin
               cnt_s = cnt_r - 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_s = IDLE;
            end else begin
               state_s = RESP;
            end
         end
         default: begin
            state_s = IDLE;
            cnt_s   = 4'd0;
         end
      endcase
   end

   // The array is touched exactly once: on the edge that enters RESP.
   assign enter_resp_s = (state_s == RESP) && (state_r != RESP);
   assign mem_we_s     = enter_resp_s & acc_write_s & ~acc_error_s;

   // State and counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
         cnt_r   <= 4'd0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
      end
   end

   // Capture the request fields on the accepting edge; ignored otherwise.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lat_write_r  <= 1'b0;
         lat_addr_r   <= 32'h0000_0000;
         lat_funct3_r <= 3'b000;
         lat_wdata_r  <= 32'h0000_0000;
      end else if (accept_s) begin
         lat_write_r  <= req_write;
         lat_addr_r   <= req_addr;
         lat_funct3_r <= req_funct3;
         lat_wdata_r  <= req_wdata;
      end
   end

   // Handshake outputs and the response payload sampled when entering RESP.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ready_r     <= 1'b0;
         rsp_valid_r <= 1'b0;
         rsp_rdata_r <= 32'h0000_0000;
         rsp_error_r <= 1'b0;
      end else begin
         ready_r <= (state_s == IDLE);
         if (enter_resp_s) begin
            rsp_valid_r <= 1'b1;
            rsp_error_r <= acc_error_s;
            rsp_rdata_r <= (acc_error_s | acc_write_s) ? 32'h0000_0000 : load_data_s;
         end else if ((state_r == RESP) && rsp_ready) begin
            rsp_valid_r <= 1'b0;
            rsp_error_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
         end
      end
   end

   // Byte-lane store commit; reset cannot reach here because no request is
   // in flight while rst is low.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         for (int b = 0; b < 4; b++) begin
            if (wmask_s[b]) begin
               mem_r[word_idx_s][8*b +: 8] <= wdata_al_s[8*b +: 8];
            end
         end
      end
   end

   assign req_ready = ready_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_rdata = rsp_rdata_r;
   assign rsp_error = rsp_error_r;

endmodule
